// File: rtl/adder_share_arb_pkg.sv
// Shared types, constants and the round-robin pick function for adder_share_arb.
package adder_share_pkg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  // One-hot grant of the first valid requester at or after ptr, wrapping at n.
  // Bits at or above n are never set, so callers may OR-reduce the full vector.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [3:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grant;
    logic [4:0]         idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      // ptr < n and k < n, so a single subtraction wraps the index
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(n)) begin
        idx = idx - 5'(n);
      end
      if (!found && (k < n) && valid[idx[3:0]]) begin
        grant[idx[3:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/adder_share_arb_csa.sv
// Carry-select adder: 4-bit blocks each precompute sums for carry-in 0 and 1,
// and the incoming block carry selects between them.
module carrySelectAdder #(
  parameter int WIDTH = 32,
  parameter int BLK_W = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int NUM_BLK = WIDTH / BLK_W;

  logic [WIDTH-1:0]   w_s0;
  logic [WIDTH-1:0]   w_s1;
  logic [NUM_BLK-1:0] w_c0;
  logic [NUM_BLK-1:0] w_c1;
  logic               w_carry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLK; gi++) begin : gen_blk
      assign {w_c0[gi], w_s0[gi*BLK_W +: BLK_W]} =
        {1'b0, i_a[gi*BLK_W +: BLK_W]} + {1'b0, i_b[gi*BLK_W +: BLK_W]};
      assign {w_c1[gi], w_s1[gi*BLK_W +: BLK_W]} =
        {1'b0, i_a[gi*BLK_W +: BLK_W]} + {1'b0, i_b[gi*BLK_W +: BLK_W]} + (BLK_W+1)'(1);
    end
  endgenerate

  // Ripple the block carry through the select muxes
  always_comb begin
    o_sum   = '0;
    w_carry = i_cin;
    for (int b = 0; b < NUM_BLK; b++) begin
      o_sum[b*BLK_W +: BLK_W] = w_carry ? w_s1[b*BLK_W +: BLK_W] : w_s0[b*BLK_W +: BLK_W];
      w_carry                 = w_carry ? w_c1[b] : w_c0[b];
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter feeding one shared carry-select adder into a
// single-entry result register with valid/ready on both sides.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_cout,
  output logic                     resp_ovf,
  output logic [CNT_W-1:0]         op_count
);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_op_count;

  logic               w_slot_free;
  logic [MAX_REQ-1:0] w_pick;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr_next;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_ovf;

  // The slot can take a new result when empty or when it drains this cycle
  assign w_slot_free = (r_state == EMPTY) || resp_ready;
  assign w_pick      = rr_pick(MAX_REQ'(req_valid), 4'(r_rr_ptr), NUM_REQ);
  assign w_accept    = w_slot_free && !rst && (|w_pick);
  assign w_grant     = w_accept ? w_pick[NUM_REQ-1:0] : '0;
  assign req_ready   = w_grant;

  // Encode the granted index and mux its operands onto the shared adder
  always_comb begin
    w_idx = '0;
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_idx = ID_W'(i);
        w_a   = req_a[i*WIDTH +: WIDTH];
        w_b   = req_b[i*WIDTH +: WIDTH];
        w_cin = req_cin[i];
      end
    end
  end

  assign w_ptr_next = (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + ID_W'(1);

  carrySelectAdder #(
    .WIDTH (DATA_W),
    .BLK_W (4)
  ) u_csa (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  // Next state: fill on accept, otherwise drain when downstream takes the result
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_state_next = FULL;
      FULL: begin
        if (w_accept) begin
          w_state_next = FULL;
        end else if (resp_ready) begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result payload, priority pointer and accept counter update only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id       <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rr_ptr   <= '0;
      r_op_count <= '0;
    end else if (w_accept) begin
      r_id       <= w_idx;
      r_sum      <= w_sum;
      r_cout     <= w_cout;
      r_ovf      <= w_ovf;
      r_rr_ptr   <= w_ptr_next;
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign resp_valid = (r_state == FULL);
  assign resp_id    = r_id;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_cout;
  assign resp_ovf   = r_ovf;
  assign op_count   = r_op_count;

endmodule
